hyper_arb: RTL and testbench

- Two-requester arbiter and command sequencer in front of the HyperRAM controller user interface (hyper_xface: rd_req/wr_req/busy/rd_rdy/burst_wr_rdy).
- Lets two independent masters, e.g. a CPU port and a DMA port, share one HyperRAM device.
- Round-robin grant; one transaction in flight at a time.
- Routes write data and burst-write pacing from the owner to the controller, and read data back to the owner, until the controller goes idle.

---
 rtl/hyper_arb.sv | 192 +++++++++++++++++++
 tb/tb_hyper_arb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_arb.sv
// hyper_arb: round-robin arbiter/sequencer sharing one hyper_xface between two masters.
// Optional watchdog abort of stuck transactions: define HYPER_ARB_WATCHDOG_EN.
module hyper_arb #(
  parameter int WDOG_CYCLES = 4096,
  parameter int START_TMO   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_mem_or_reg,
  input  logic [3:0]  m0_byte_en,
  input  logic [21:0] m0_num_dwords,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_d,
  output logic        m0_gnt,
  output logic [31:0] m0_rd_d,
  output logic        m0_rd_rdy,
  output logic        m0_burst_wr_rdy,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_mem_or_reg,
  input  logic [3:0]  m1_byte_en,
  input  logic [21:0] m1_num_dwords,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_d,
  output logic        m1_gnt,
  output logic [31:0] m1_rd_d,
  output logic        m1_rd_rdy,
  output logic        m1_burst_wr_rdy,
  output logic        m1_done,
  output logic        m1_err,
  output logic        rd_req,
  output logic        wr_req,
  output logic        mem_or_reg,
  output logic [3:0]  wr_byte_en,
  output logic [21:0] rd_num_dwords,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  input  logic        busy,
  input  logic        burst_wr_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  localparam logic [31:0] ST_LAST = 32'(START_TMO - 1);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        pick;
  logic        any_req;
  logic        active;
  logic        wd_trip;
  logic [31:0] st_cnt;

  assign any_req = m0_req | m1_req;
  // Tie goes to whoever did not win last time.
  assign pick    = (m0_req & m1_req) ? ~last_grant : m1_req;
  assign active  = (state != S_IDLE);

  assign m0_rd_d         = (active && !owner) ? rd_d : '0;
  assign m1_rd_d         = (active &&  owner) ? rd_d : '0;
  assign m0_rd_rdy       = active & ~owner & rd_rdy;
  assign m1_rd_rdy       = active &  owner & rd_rdy;
  assign m0_burst_wr_rdy = active & ~owner & burst_wr_rdy;
  assign m1_burst_wr_rdy = active &  owner & burst_wr_rdy;
  assign wr_d            = !active ? '0 : (owner ? m1_wr_d : m0_wr_d);

`ifdef HYPER_ARB_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(WDOG_CYCLES - 1);

  logic [31:0] wd_cnt;
  logic        wd_flag;
  logic        err0_q;
  logic        err1_q;

  assign wd_trip = (wd_cnt == WD_LAST);
  assign m0_err  = err0_q;
  assign m1_err  = err1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE || (state == S_WAIT_START && busy))
        wd_cnt <= '0;
      else if (state == S_WAIT_START || state == S_WAIT_DONE)
        wd_cnt <= wd_cnt + 32'd1;
      if (state == S_WAIT_DONE && busy && wd_trip) begin
        err0_q  <= ~owner;
        err1_q  <= owner;
        wd_flag <= 1'b1;
      end else begin
        err0_q <= 1'b0;
        err1_q <= 1'b0;
      end
    end
  end
`else
  assign wd_trip = 1'b0;
  assign m0_err  = 1'b0;
  assign m1_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      st_cnt        <= '0;
      m0_gnt        <= 1'b0;
      m1_gnt        <= 1'b0;
      rd_req        <= 1'b0;
      wr_req        <= 1'b0;
      m0_done       <= 1'b0;
      m1_done       <= 1'b0;
      mem_or_reg    <= 1'b0;
      wr_byte_en    <= '0;
      rd_num_dwords <= '0;
      addr          <= '0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      rd_req  <= 1'b0;
      wr_req  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!busy && any_req) begin
            state         <= S_ISSUE;
            owner         <= pick;
            m0_gnt        <= ~pick;
            m1_gnt        <= pick;
            wr_req        <= pick ? m1_we : m0_we;
            rd_req        <= pick ? ~m1_we : ~m0_we;
            mem_or_reg    <= pick ? m1_mem_or_reg : m0_mem_or_reg;
            wr_byte_en    <= pick ? m1_byte_en : m0_byte_en;
            rd_num_dwords <= pick ? m1_num_dwords : m0_num_dwords;
            addr          <= pick ? m1_addr : m0_addr;
          end
        end
        S_ISSUE: begin
          last_grant <= owner;
          st_cnt     <= '0;
          state      <= S_WAIT_START;
        end
        S_WAIT_START: begin
          st_cnt <= st_cnt + 32'd1;
          if (busy) begin
            state <= S_WAIT_DONE;
          end else if (st_cnt == ST_LAST) begin
            // controller finished before we could see busy
            state   <= S_DONE;
            m0_done <= ~owner;
            m1_done <= owner;
          end
        end
        S_WAIT_DONE: begin
          if (!busy || wd_trip) begin
            state   <= S_DONE;
            m0_done <= ~owner;
            m1_done <= owner;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          mem_or_reg    <= 1'b0;
          wr_byte_en    <= '0;
          rd_num_dwords <= '0;
          addr          <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_arb.sv
// tb_hyper_arb: directed self-checking bench for hyper_arb.
// Watchdog scenario selected by HYPER_ARB_WATCHDOG_EN.
module tb_hyper_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_mem_or_reg;
  logic [3:0]  m0_byte_en;
  logic [21:0] m0_num_dwords;
  logic [31:0] m0_addr, m0_wr_d;
  logic        m0_gnt, m0_rd_rdy, m0_burst_wr_rdy, m0_done, m0_err;
  logic [31:0] m0_rd_d;
  logic        m1_req, m1_we, m1_mem_or_reg;
  logic [3:0]  m1_byte_en;
  logic [21:0] m1_num_dwords;
  logic [31:0] m1_addr, m1_wr_d;
  logic        m1_gnt, m1_rd_rdy, m1_burst_wr_rdy, m1_done, m1_err;
  logic [31:0] m1_rd_d;
  logic        rd_req, wr_req, mem_or_reg;
  logic [3:0]  wr_byte_en;
  logic [21:0] rd_num_dwords;
  logic [31:0] addr, wr_d, rd_d;
  logic        rd_rdy, busy, burst_wr_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hyper_arb #(.WDOG_CYCLES(32), .START_TMO(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mem_or_reg(m0_mem_or_reg),
    .m0_byte_en(m0_byte_en), .m0_num_dwords(m0_num_dwords),
    .m0_addr(m0_addr), .m0_wr_d(m0_wr_d), .m0_gnt(m0_gnt),
    .m0_rd_d(m0_rd_d), .m0_rd_rdy(m0_rd_rdy),
    .m0_burst_wr_rdy(m0_burst_wr_rdy), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mem_or_reg(m1_mem_or_reg),
    .m1_byte_en(m1_byte_en), .m1_num_dwords(m1_num_dwords),
    .m1_addr(m1_addr), .m1_wr_d(m1_wr_d), .m1_gnt(m1_gnt),
    .m1_rd_d(m1_rd_d), .m1_rd_rdy(m1_rd_rdy),
    .m1_burst_wr_rdy(m1_burst_wr_rdy), .m1_done(m1_done), .m1_err(m1_err),
    .rd_req(rd_req), .wr_req(wr_req), .mem_or_reg(mem_or_reg),
    .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords),
    .addr(addr), .wr_d(wr_d), .rd_d(rd_d), .rd_rdy(rd_rdy),
    .busy(busy), .burst_wr_rdy(burst_wr_rdy)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_mem_or_reg = 0; m0_byte_en = '0;
    m0_num_dwords = '0; m0_addr = '0; m0_wr_d = '0;
    m1_req = 0; m1_we = 0; m1_mem_or_reg = 0; m1_byte_en = '0;
    m1_num_dwords = '0; m1_addr = '0; m1_wr_d = '0;
    rd_d = '0; rd_rdy = 0; busy = 0; burst_wr_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    m0_req = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, rd_req, wr_req, m0_done, m1_done, m0_err, m1_err} !== 8'h0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 00000000",
               {m0_gnt, m1_gnt, rd_req, wr_req, m0_done, m1_done, m0_err, m1_err});
    end
    checks++;
    if ({addr, wr_d, rd_num_dwords, wr_byte_en, mem_or_reg} !== '0) begin
      errors++;
      $display("FAIL reset_fields: addr=%h wr_d=%h num=%h be=%h mor=%b want all 0",
               addr, wr_d, rd_num_dwords, wr_byte_en, mem_or_reg);
    end
    m0_req = 0;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_write();
    m0_req = 1; m0_we = 1; m0_addr = 32'h100;
    m0_wr_d = 32'hA5A5A5A5; m0_byte_en = 4'hF;
    @(negedge clk);
    checks++;
    if ({m0_gnt, wr_req, rd_req, m1_gnt} !== 4'b1100) begin
      errors++;
      $display("FAIL wr_issue: gnt0/wr/rd/gnt1 got %b want 1100",
               {m0_gnt, wr_req, rd_req, m1_gnt});
    end
    checks++;
    if (addr !== 32'h100 || wr_d !== 32'hA5A5A5A5 || wr_byte_en !== 4'hF) begin
      errors++;
      $display("FAIL wr_cmd: addr=%h wr_d=%h be=%h want 100 a5a5a5a5 f",
               addr, wr_d, wr_byte_en);
    end
    m0_req = 0; busy = 1; burst_wr_rdy = 1; m0_wr_d = 32'h5A5A5A5A;
    #1;
    checks++;
    if ({m0_burst_wr_rdy, m1_burst_wr_rdy} !== 2'b10 || wr_d !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL wr_burst: bwr0/bwr1 got %b wr_d=%h want 10 5a5a5a5a",
               {m0_burst_wr_rdy, m1_burst_wr_rdy}, wr_d);
    end
    @(negedge clk);
    burst_wr_rdy = 0;
    @(negedge clk);
    checks++;
    if (m0_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_early_done: got %b want 0", m0_done);
    end
    busy = 0;
    @(negedge clk);
    checks++;
    if ({m0_done, m0_err, m1_done, m1_gnt} !== 4'b1000 || addr !== 32'h100) begin
      errors++;
      $display("FAIL wr_done: done0/err0/done1/gnt1 got %b addr=%h want 1000 100",
               {m0_done, m0_err, m1_done, m1_gnt}, addr);
    end
    @(negedge clk);
    checks++;
    if (m0_done !== 1'b0 || addr !== 32'h0 || wr_d !== 32'h0) begin
      errors++;
      $display("FAIL wr_idle: done0=%b addr=%h wr_d=%h want 0 0 0", m0_done, addr, wr_d);
    end
  endtask

  task automatic test_read();
    bit seen;
    logic [31:0] exp;
    m1_req = 1; m1_we = 0; m1_addr = 32'h40; m1_num_dwords = 22'd4; m1_mem_or_reg = 1;
    @(negedge clk);
    checks++;
    if ({m1_gnt, rd_req, wr_req, m0_gnt, mem_or_reg} !== 5'b11001 ||
        rd_num_dwords !== 22'd4 || addr !== 32'h40) begin
      errors++;
      $display("FAIL rd_issue: gnt1/rd/wr/gnt0/mor got %b num=%0d addr=%h want 11001 4 40",
               {m1_gnt, rd_req, wr_req, m0_gnt, mem_or_reg}, rd_num_dwords, addr);
    end
    m1_req = 0; busy = 1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'hC0DE0000 + 32'(i);
      rd_rdy = 1; rd_d = exp;
      #1;
      checks++;
      if ({m1_rd_rdy, m0_rd_rdy} !== 2'b10 || m1_rd_d !== exp || m0_rd_d !== 32'h0) begin
        errors++;
        $display("FAIL rd_beat%0d: rdy1/rdy0 got %b d1=%h d0=%h want 10 %h 0",
                 i, {m1_rd_rdy, m0_rd_rdy}, m1_rd_d, m0_rd_d, exp);
      end
      @(negedge clk);
      rd_rdy = 0;
      @(negedge clk);
    end
    busy = 0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (m1_done) seen = 1;
    end
    checks++;
    if (!seen || m0_done !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: seen=%b done0=%b want 1 0", seen, m0_done);
    end
    @(negedge clk);
  endtask

  task automatic test_dropped_rdy();
    rd_rdy = 1; burst_wr_rdy = 1; rd_d = 32'hFFFF0000;
    #1;
    checks++;
    if ({m0_rd_rdy, m1_rd_rdy, m0_burst_wr_rdy, m1_burst_wr_rdy} !== 4'b0 ||
        m0_rd_d !== 32'h0 || m1_rd_d !== 32'h0) begin
      errors++;
      $display("FAIL idle_drop: strobes got %b d0=%h d1=%h want 0000 0 0",
               {m0_rd_rdy, m1_rd_rdy, m0_burst_wr_rdy, m1_burst_wr_rdy}, m0_rd_d, m1_rd_d);
    end
    rd_rdy = 0; burst_wr_rdy = 0; rd_d = '0;
    @(negedge clk);
  endtask

  task automatic test_start_tmo();
    m0_req = 1; m0_we = 0; m0_addr = 32'h200; m0_num_dwords = 22'd1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, rd_req} !== 2'b11) begin
      errors++;
      $display("FAIL tmo_issue: gnt0/rd got %b want 11", {m0_gnt, rd_req});
    end
    m0_req = 0;
    repeat (16) @(negedge clk);
    checks++;
    if (m0_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: done0 got %b want 0", m0_done);
    end
    @(negedge clk);
    checks++;
    if ({m0_done, m0_err} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_done: done0/err0 got %b want 10", {m0_done, m0_err});
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit got, seen;
    logic exp_m1;
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'hA0;
    m1_req = 1; m1_we = 0; m1_addr = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      exp_m1 = k[0];
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (m0_gnt || m1_gnt) got = 1;
      end
      checks++;
      if (!got || {m1_gnt, m0_gnt} !== {exp_m1, ~exp_m1} ||
          addr !== (exp_m1 ? 32'hB0 : 32'hA0)) begin
        errors++;
        $display("FAIL rr_gnt%0d: got=%b gnt1/gnt0=%b addr=%h want 1 %b%b %h",
                 k, got, {m1_gnt, m0_gnt}, addr, exp_m1, ~exp_m1,
                 exp_m1 ? 32'hB0 : 32'hA0);
      end
      busy = 1;
      repeat (2) @(negedge clk);
      busy = 0;
      seen = 0;
      for (int i = 0; i < 5 && !seen; i++) begin
        @(negedge clk);
        if (m0_done || m1_done) seen = 1;
      end
      checks++;
      if (!seen || {m1_done, m0_done} !== {exp_m1, ~exp_m1}) begin
        errors++;
        $display("FAIL rr_done%0d: seen=%b done1/done0=%b want 1 %b%b",
                 k, seen, {m1_done, m0_done}, exp_m1, ~exp_m1);
      end
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_hold();
    bit bad, seen;
    busy = 1; m0_req = 1; m0_we = 1; m0_addr = 32'h300;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (m0_gnt || wr_req) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_block: grant while busy got 1 want 0");
    end
    busy = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, wr_req} !== 2'b11) begin
      errors++;
      $display("FAIL busy_release: gnt0/wr got %b want 11", {m0_gnt, wr_req});
    end
    m0_req = 0; busy = 1;
    repeat (2) @(negedge clk);
    busy = 0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (m0_done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_done: done0 seen got 0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wr_d = 32'hDEADBEEF;
    m1_byte_en = 4'h3; m1_mem_or_reg = 1;
    @(negedge clk);
    checks++;
    if ({m1_gnt, wr_req} !== 2'b11) begin
      errors++;
      $display("FAIL rst_issue: gnt1/wr got %b want 11", {m1_gnt, wr_req});
    end
    m1_req = 0; busy = 1;
    repeat (3) @(negedge clk);
    reset = 1; busy = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, rd_req, wr_req, m0_done, m1_done, mem_or_reg} !== 7'h0 ||
        addr !== 32'h0 || wr_d !== 32'h0 || wr_byte_en !== 4'h0 ||
        rd_num_dwords !== 22'h0) begin
      errors++;
      $display("FAIL rst_mid: flags=%b addr=%h wr_d=%h be=%h num=%h want all 0",
               {m0_gnt, m1_gnt, rd_req, wr_req, m0_done, m1_done, mem_or_reg},
               addr, wr_d, wr_byte_en, rd_num_dwords);
    end
    reset = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (m1_done || m0_done) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_nodone: done after reset got 1 want 0");
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    bit seen;
    m0_req = 1; m0_we = 1; m0_addr = 32'h400;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wd_issue: gnt0 got %b want 1", m0_gnt);
    end
    m0_req = 0; busy = 1;
`ifdef HYPER_ARB_WATCHDOG_EN
    repeat (33) @(negedge clk);
    checks++;
    if (m0_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: done0 got %b want 0", m0_done);
    end
    @(negedge clk);
    checks++;
    if ({m0_done, m0_err, m1_done, m1_err} !== 4'b1100) begin
      errors++;
      $display("FAIL wd_abort: done0/err0/done1/err1 got %b want 1100",
               {m0_done, m0_err, m1_done, m1_err});
    end
    m1_req = 1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m1_gnt || m0_done || m0_err) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL wd_hold: activity while busy stuck got 1 want 0");
    end
`else
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (m0_done || m0_err || m1_done || m1_err) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL wd_absent: done/err with busy stuck got 1 want 0");
    end
`endif
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_dropped_rdy();
    test_start_tmo();
    test_fairness();
    test_busy_hold();
    test_reset_mid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
